// File: rtl/scan_display.sv
// Time-multiplexed seven-segment scan driver: one digit per slot, with dead time,
// per-digit dp/blank/blink, leading-zero suppression and a frame-start pulse.
module scan_display #(
   parameter int DIGITS         = 8,
   parameter int SCAN_DIV       = 1000,
   parameter int BLANK_CYC      = 2,
   parameter int BLINK_DIV      = 8,
   parameter int ACTIVE_LOW_SEG = 0
) (
   input  logic                  CP,
   input  logic                  nCR,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic [DIGITS-1:0]     blink,
   input  logic                  lz_en,
   output logic [7:0]            codeout,
   output logic [DIGITS-1:0]     seg,
   output logic                  frame_sync
);

   localparam int IW = $clog2(DIGITS);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int FW = $clog2(BLINK_DIV + 1);

   localparam logic [CW-1:0] CNT_LAST    = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_START = CW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_LAST    = IW'(DIGITS - 1);
   localparam logic [FW-1:0] FRM_LAST    = FW'(BLINK_DIV - 1);
   localparam logic [7:0]    INACTIVE    = (ACTIVE_LOW_SEG != 0) ? 8'hFF : 8'h00;

   logic [CW-1:0]     cnt;
   logic [IW-1:0]     idx;
   logic [FW-1:0]     frame_cnt;
   logic              blink_off;

   logic [3:0]        snap_nib;
   logic              snap_dp;
   logic              snap_blank;
   logic              snap_blink;
   logic              snap_supp;

   logic [DIGITS-1:0] supp_vec;
   logic              zero_run;
   logic [DIGITS-1:0] sel;
   logic [7:0]        dec;
   logic              visible;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   // Walk from the most significant digit down so zero_run covers digits i..DIGITS-1.
   always_comb begin
      // NOTE: every always_comb output gets a default before any branch or loop, so no latch is inferred.
      supp_vec = '0;
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run    = zero_run & (data[4*i +: 4] == 4'h0) & ~dp[i];
         supp_vec[i] = lz_en & zero_run & (i != 0);
      end
   end

   always_comb begin
      sel      = '0;
      sel[idx] = 1'b1;
   end

   assign dec     = {snap_dp, hex7(snap_nib)};
   assign visible = ~snap_blank & ~snap_supp & ~(snap_blink & blink_off);

   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         cnt        <= '0;
         idx        <= '0;
         frame_cnt  <= '0;
         blink_off  <= 1'b0;
         snap_nib   <= 4'h0;
         snap_dp    <= 1'b0;
         snap_blank <= 1'b0;
         snap_blink <= 1'b0;
         snap_supp  <= 1'b0;
         seg        <= '0;
         codeout    <= INACTIVE;
         frame_sync <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every term below sees pre-edge values.
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
               idx <= '0;
               if (frame_cnt == FRM_LAST) begin
                  frame_cnt <= '0;
                  blink_off <= ~blink_off;
               end else begin
                  frame_cnt <= frame_cnt + 1'b1;
               end
            end else begin
               idx <= idx + 1'b1;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end

         // The snapshot is taken inside the dead time, so a slot never shows mixed inputs.
         if (cnt == '0) begin
            snap_nib   <= data[4*idx +: 4];
            snap_dp    <= dp[idx];
            snap_blank <= blank[idx];
            snap_blink <= blink[idx];
            snap_supp  <= supp_vec[idx];
         end

         frame_sync <= (cnt == CNT_LAST) && (idx == IDX_LAST);

         if ((cnt >= BLANK_START) && visible) begin
            seg     <= sel;
            codeout <= dec ^ INACTIVE;
         end else begin
            seg     <= '0;
            codeout <= INACTIVE;
         end
      end
   end

endmodule

// File: tb/tb_scan_display.sv
// Directed bench for scan_display: 4 digits, 4-cycle slots, 1 dead cycle, blink every 2 frames,
// with an active-high and an active-low instance driven from the same inputs.
module tb_scan_display;

   logic        CP  = 1'b0;
   logic        nCR = 1'b1;
   logic [15:0] data;
   logic [3:0]  dp, blank, blink;
   logic        lz_en;

   logic [7:0]  codeout, codeout_al;
   logic [3:0]  seg, seg_al;
   logic        frame_sync, frame_sync_al;

   int tests = 0;
   int fails = 0;

   scan_display #(
      .DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_DIV(2), .ACTIVE_LOW_SEG(0)
   ) u_dut (
      .CP(CP), .nCR(nCR), .data(data), .dp(dp), .blank(blank), .blink(blink),
      .lz_en(lz_en), .codeout(codeout), .seg(seg), .frame_sync(frame_sync)
   );

   scan_display #(
      .DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_DIV(2), .ACTIVE_LOW_SEG(1)
   ) u_dut_al (
      .CP(CP), .nCR(nCR), .data(data), .dp(dp), .blank(blank), .blink(blink),
      .lz_en(lz_en), .codeout(codeout_al), .seg(seg_al), .frame_sync(frame_sync_al)
   );

   always #5 CP = ~CP;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CP);
      #1;
   endtask

   // One full slot: a dead sample, then three samples of es/ec; frame_sync only on the last sample of efs slots.
   task automatic slot(input string tag, input logic [3:0] es, input logic [7:0] ec, input logic efs);
      for (int j = 0; j < 4; j++) begin
         tick();
         if (j == 0) begin
            chk({tag, " dead seg"}, seg, 4'b0000);
            chk({tag, " dead code"}, codeout, 8'h00);
            chk({tag, " dead code_al"}, codeout_al, 8'hFF);
            chk({tag, " dead seg_al"}, seg_al, 4'b0000);
         end else begin
            chk({tag, " seg"}, seg, es);
            chk({tag, " code"}, codeout, ec);
            chk({tag, " code_al"}, codeout_al, ec ^ 8'hFF);
            chk({tag, " seg_al"}, seg_al, es);
         end
         chk({tag, " frame_sync"}, frame_sync, efs && (j == 3));
      end
   endtask

   initial begin
      data  = 16'h1234;
      dp    = 4'b0000;
      blank = 4'b0000;
      blink = 4'b0000;
      lz_en = 1'b0;

      #1 nCR = 1'b0;
      #1;
      chk("reset seg", seg, 4'b0000);
      chk("reset code", codeout, 8'h00);
      chk("reset code_al", codeout_al, 8'hFF);
      chk("reset frame_sync", frame_sync, 1'b0);
      tick();
      tick();
      chk("reset held seg", seg, 4'b0000);
      chk("reset held frame_sync", frame_sync, 1'b0);
      @(negedge CP) nCR = 1'b1;

      // Scan order, two frames
      for (int f = 0; f < 2; f++) begin
         slot("scan d0", 4'b0001, 8'h66, 1'b0);
         slot("scan d1", 4'b0010, 8'h4F, 1'b0);
         slot("scan d2", 4'b0100, 8'h5B, 1'b0);
         slot("scan d3", 4'b1000, 8'h06, 1'b1);
      end

      // Leading-zero suppression
      data = 16'h0005; lz_en = 1'b1;
      slot("lz on d0", 4'b0001, 8'h6D, 1'b0);
      slot("lz on d1", 4'b0000, 8'h00, 1'b0);
      slot("lz on d2", 4'b0000, 8'h00, 1'b0);
      slot("lz on d3", 4'b0000, 8'h00, 1'b1);

      lz_en = 1'b0;
      slot("lz off d0", 4'b0001, 8'h6D, 1'b0);
      slot("lz off d1", 4'b0010, 8'h3F, 1'b0);
      slot("lz off d2", 4'b0100, 8'h3F, 1'b0);
      slot("lz off d3", 4'b1000, 8'h3F, 1'b1);

      data = 16'h0000; lz_en = 1'b1;
      slot("lz zero d0", 4'b0001, 8'h3F, 1'b0);
      slot("lz zero d1", 4'b0000, 8'h00, 1'b0);
      slot("lz zero d2", 4'b0000, 8'h00, 1'b0);
      slot("lz zero d3", 4'b0000, 8'h00, 1'b1);

      data = 16'h0005; dp = 4'b0100;
      slot("lz dp d0", 4'b0001, 8'h6D, 1'b0);
      slot("lz dp d1", 4'b0010, 8'h3F, 1'b0);
      slot("lz dp d2", 4'b0100, 8'hBF, 1'b0);
      slot("lz dp d3", 4'b0000, 8'h00, 1'b1);

      // Mid-slot asynchronous reset while digit 2 is lit
      data = 16'h1234; dp = 4'b0000; lz_en = 1'b0;
      slot("pre-rst d0", 4'b0001, 8'h66, 1'b0);
      slot("pre-rst d1", 4'b0010, 8'h4F, 1'b0);
      tick();
      tick();
      chk("pre-rst d2 seg", seg, 4'b0100);
      chk("pre-rst d2 code", codeout, 8'h5B);
      #2 nCR = 1'b0;
      #1;
      chk("async rst seg", seg, 4'b0000);
      chk("async rst code", codeout, 8'h00);
      chk("async rst code_al", codeout_al, 8'hFF);
      chk("async rst frame_sync", frame_sync, 1'b0);
      blink = 4'b0010;
      @(negedge CP) nCR = 1'b1;

      // Blink: frames 0-1 lit, 2-3 dark, 4 lit; frame 5 blanked
      for (int f = 0; f < 6; f++) begin
         if (f == 5) blank = 4'b0010;
         slot("blink d0", 4'b0001, 8'h66, 1'b0);
         if (f == 2 || f == 3 || f == 5)
            slot("blink d1 dark", 4'b0000, 8'h00, 1'b0);
         else
            slot("blink d1 lit", 4'b0010, 8'h4F, 1'b0);
         slot("blink d2", 4'b0100, 8'h5B, 1'b0);
         slot("blink d3", 4'b1000, 8'h06, 1'b1);
      end

      // Snapshot stability: digit 1 changes 3 -> 8 mid-slot
      blank = 4'b0000; blink = 4'b0000;
      slot("snap d0", 4'b0001, 8'h66, 1'b0);
      tick();
      chk("snap d1 dead seg", seg, 4'b0000);
      tick();
      chk("snap d1 before code", codeout, 8'h4F);
      data = 16'h1284;
      tick();
      chk("snap d1 after seg", seg, 4'b0010);
      chk("snap d1 after code", codeout, 8'h4F);
      tick();
      chk("snap d1 end code", codeout, 8'h4F);
      chk("snap d1 end frame_sync", frame_sync, 1'b0);
      slot("snap d2", 4'b0100, 8'h5B, 1'b0);
      slot("snap d3", 4'b1000, 8'h06, 1'b1);
      slot("snap next d0", 4'b0001, 8'h66, 1'b0);
      slot("snap next d1", 4'b0010, 8'h7F, 1'b0);
      tick();
      tick();
      chk("active-low d2 code_al", codeout_al, 8'hA4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/scan_display.md
# scan_display

Parametrised time-multiplexed seven-segment scan driver for the clock front panel. It drives `DIGITS` common-select digits from a packed hex/BCD word, with optional per-digit decimal point, forced blanking, blink and leading-zero suppression. Each digit slot has a programmable dead time against ghosting. It replaces the fixed 8-slot printer and sits between the timekeeping/mode logic and the board's segment and digit-select pins.

## Interface
- `DIGITS`, 8: number of digits; must be ≥2. `idx` width is clog2(DIGITS).
- `SCAN_DIV`, 1000: CP cycles per digit slot; must be ≥2.
- `BLANK_CYC`, 2: dead cycles at the start of each slot with `seg` all zero; 1 ≤ BLANK_CYC < SCAN_DIV.
- `BLINK_DIV`, 8: completed frames per blink phase; must be ≥1.
- `ACTIVE_LOW_SEG`, 0: 1 inverts all of `codeout`. `seg` is always active-high.
- `CP` in 1: clock; all state changes on its rising edge.
- `nCR` in 1: asynchronous, active-low reset.
- `data` in 4*DIGITS: nibble per digit; digit 0 (rightmost) is `data[3:0]`.
- `dp` in DIGITS: decimal point per digit.
- `blank` in DIGITS: force digit dark.
- `blink` in DIGITS: digit goes dark during the off blink phase.
- `lz_en` in 1: leading-zero suppression enable.
- `codeout` out 8: segments {dp,g,f,e,d,c,b,a}, registered.
- `seg` out DIGITS: one-hot digit select, registered; bit i selects digit i.
- `frame_sync` out 1: one-cycle pulse at the start of each frame.

## Operation
- **Counters.**
  - `cnt` runs 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and `idx` advances.
  - `idx` runs 0..DIGITS-1 and wraps to 0, so no dead slots exist for any DIGITS.
- **Snapshot.** On the edge where state `cnt`==0, the following are captured for the current `idx`:
  - nibble `data[4*idx+3:4*idx]`, `dp[idx]`, `blank[idx]`, `blink[idx]`
  - the suppression flag
  
  Input changes during a slot never alter that slot's output.
- **Suppression.** Digit idx is suppressed when all of these hold:
  - `lz_en`=1 and idx>0
  - all nibbles idx..DIGITS-1 are 0
  - all `dp` bits idx..DIGITS-1 are 0
  
  Digit 0 is never suppressed.
- **Visibility.** `visible` = !blank && !suppressed && !(blink && blink_off).
- **Decode (hex, segment bit = 1 means lit).**
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71
  - bit7 = dp. The whole byte is inverted if ACTIVE_LOW_SEG=1.
- **Output registers, every edge.**
  - If state `cnt` ≥ BLANK_CYC and `visible`: `seg` ← onehot(idx) and `codeout` ← decoded snapshot.
  - Otherwise: `seg` ← 0 and `codeout` ← inactive (00, or FF when active-low).
- **Blink.**
  - A frame counter counts idx wraps DIGITS-1→0.
  - Reaching BLINK_DIV wraps the counter to 0 and toggles `blink_off`.
  - The phase changes only at a frame boundary.
- **frame_sync.** Registered high for one cycle following the edge where idx wraps to 0. No pulse is generated by reset release.

## Timing
- **Reset.** With `nCR`=0, all of the following are forced asynchronously, including mid-slot:
  - `cnt`=0, `idx`=0, frame counter 0, `blink_off`=0, snapshot cleared
  - `seg`=0, `codeout`=inactive, `frame_sync`=0
- **Output latency.** Outputs lag counter state by one cycle.
- **Slot shape.** Per slot, `seg` is active for exactly SCAN_DIV-BLANK_CYC consecutive cycles and 0 for BLANK_CYC cycles. `codeout` is constant while `seg` is active.
- **Frame.** A frame is DIGITS*SCAN_DIV cycles, and `frame_sync` period equals the frame.
- **First output.** The first digit-0 output appears after edge BLANK_CYC+1 following reset release.
- **Input latency.** An input change is displayed at the next slot of that digit: at most DIGITS*SCAN_DIV+BLANK_CYC+1 cycles.
- **Simultaneous events.** Snapshot, idx advance, frame count and blink toggle coinciding on one edge all use the pre-edge state. There is no priority conflict.

## Test plan
- **Reset.** Assert `nCR` mid-slot with `seg`=0100 → `seg`=0, `codeout`=00 and `frame_sync`=0 immediately without a clock edge. After release, counting restarts at idx 0.
- **Scan order.** DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, data=16'h1234, lz_en=0 → repeating pattern, frame_sync pulsing every 16 cycles:
  - off 1 cycle, then 0001/66 ×3
  - off 1, then 0010/4F ×3
  - off 1, then 0100/5B ×3
  - off 1, then 1000/06 ×3
- **Leading-zero suppression.**
  - data=16'h0005, lz_en=1 → only slot 0 lights (0001/6D); slots 1-3 `seg`=0.
  - lz_en=0 → slots 1-3 show 3F.
  - data=0, lz_en=1 → digit 0 shows 3F.
  - data=16'h0005, dp=0100 → digit2 BF and digit1 3F are shown; digit3 is dark.
- **Blink.** BLINK_DIV=2, blink=0010 → digit1 lit in frames 0-1, dark in frames 2-3, lit in frames 4-5. Other digits are unaffected, and blank=0010 keeps digit1 dark in every frame.
- **Snapshot stability.** Change data[7:4] from 3 to 8 mid-slot of digit1 → `codeout` stays 4F for the rest of that slot; the next digit1 slot shows 7F.
- **Active-low segments.** ACTIVE_LOW_SEG=1, data=16'h1234 → slot0 `codeout`=99 and dead cycles show FF. `seg` polarity is unchanged.
